seq_stim_tx: RTL and testbench
==============================

Name: seq_stim_tx

Overview:
Serial pattern transmitter that drives the single-bit input of the team's sequence-detector FSMs.
- Accepts a parallel pattern word plus a bit count over a valid/ready handshake.
- Optionally emits a one-cycle state-reset strobe first, then shifts the pattern out MSB-first, one bit per clk.
- Used as the stimulus/source end of the detector's in_data / in_state_reset interface in lab top-levels and benches.

Parameters:
- WIDTH, 8, pattern word width in bits (2..16).
- LEN_W, 5, width of length field; must satisfy 2**LEN_W > WIDTH.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
- in_pattern  input  WIDTH  pattern; bit WIDTH-1 is sent first.
- in_len  input  LEN_W  number of bits to send from the MSB end; 0 = empty request.
- in_reset_first  input  1  1 = emit a state-reset strobe before the first bit.
- in_abort  input  1  synchronous abort of the current frame.
- out_data  output  1  serial bit to the detector in_data.
- out_state_reset  output  1  strobe to the detector in_state_reset.
- out_bit_valid  output  1  out_data carries a pattern bit this cycle.
- out_done  output  1  one-cycle pulse coincident with the last bit of a frame.
- out_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: clk is clk, reset is rst_n, asynchronous, active-low.
  - State = IDLE; shift register, remaining counter and all outputs = 0.
  - in_ready is combinational and therefore 1 in IDLE once rst_n is released.
- FSM states: IDLE, RST, SHIFT. All outputs except in_ready are registered or decoded from registered state. No combinational path from in_* to out_*.
- IDLE:
  - in_ready = 1; out_data = 0; out_bit_valid = 0.
  - On accept with effective length L > 0:
    - shreg <= in_pattern; rem <= L.
    - Next state = RST if in_reset_first, else SHIFT.
  - On accept with L == 0: request consumed, stay in IDLE, no outputs, no done pulse.
- Length clamp: L = min(in_len, WIDTH).
- RST:
  - Lasts exactly 1 cycle; out_state_reset = 1, out_bit_valid = 0, out_data = 0.
  - Then goes to SHIFT.
- SHIFT:
  - out_data = shreg[WIDTH-1]; out_bit_valid = 1.
  - Each cycle: shreg shifts left with 0 fill; rem decrements.
  - On the cycle with rem == 1: out_done = 1.
- Back-to-back:
  - in_ready = 1 also in SHIFT when rem == 1.
  - An accept on that cycle loads the new request and goes to RST or SHIFT directly. The new frame's first bit (or strobe) appears the next cycle with no idle gap.
  - No accept on that cycle: return to IDLE.
- Latency:
  - Accept at edge T, no reset_first: bit 1 appears after T, bit L after T+L-1.
  - With reset_first: strobe after T, bits shifted one cycle later.
- Abort:
  - in_abort = 1 at an edge in RST or SHIFT forces IDLE and clears shreg and rem.
  - No out_done is generated.
  - in_abort has priority over a simultaneous accept: the request is not consumed, because in_ready is forced to 0 while in_abort = 1.
  - in_abort in IDLE has no effect other than in_ready = 0 that cycle.
- rst_n asserted mid-frame: immediate return to the reset state; the frame is lost; no done pulse.
- out_busy = (state != IDLE).
- in_pattern, in_len and in_reset_first are sampled only on accept; later changes are ignored.

Test Plan:
- Reset, then accept pattern 8'b1011_0000, len = 4, reset_first = 0.
  - Required: out_data = 1, 0, 1, 1 on 4 consecutive cycles starting 1 cycle after accept.
  - Required: out_bit_valid high for those 4 cycles; out_done on the 4th; then IDLE with in_ready = 1.
- Pattern 8'hA5, len = 8, reset_first = 1.
  - Required: out_state_reset high for 1 cycle, then bits 1,0,1,0,0,1,0,1.
  - Required: driving the 3-bit detector, its out_cur_state = 0 after the strobe.
- Back-to-back: second request (8'hC0, len = 2) held valid during the first frame.
  - Required: accepted on the last-bit cycle of the first frame.
  - Required: bits 1,1 follow with no gap; two out_done pulses.
- len = 0, then len = 12 with WIDTH = 8.
  - Required: len = 0 is consumed with no output activity.
  - Required: len = 12 sends exactly 8 bits.
- in_abort on the 3rd bit of an 8-bit frame, with in_valid held.
  - Required: IDLE next cycle, no out_done.
  - Required: in_ready = 0 during abort; the pending request is accepted the cycle after abort deasserts.
- rst_n pulsed low asynchronously mid-SHIFT.
  - Required: all outputs 0 immediately.
  - Required: after release, a new frame works normally.

Source files
------------

// File: rtl/seq_stim_tx.sv
// Serial pattern transmitter: accepts a pattern word over valid/ready, optionally
// strobes the detector's state reset, then shifts the pattern out MSB-first.
module seq_stim_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pattern,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_reset_first,
    input  logic             in_abort,
    output logic             out_data,
    output logic             out_state_reset,
    output logic             out_bit_valid,
    output logic             out_done,
    output logic             out_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shreg;
    logic [LEN_W-1:0]   rem;
    logic [LEN_W-1:0]   len_eff;
    logic               last_bit;
    logic               load;

    // Requests longer than the word are clamped to the full word.
    assign len_eff  = (in_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : in_len;
    assign last_bit = (state == SHIFT) && (rem == LEN_W'(1));
    assign load     = in_valid && in_ready && (len_eff != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            rem   <= '0;
        end else if (load) begin
            shreg <= in_pattern;
            rem   <= len_eff;
        end else if (in_abort && (state != IDLE)) begin
            shreg <= '0;
            rem   <= '0;
        end else if (state == SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            rem   <= rem - LEN_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) state_next = in_reset_first ? RST : SHIFT;
            end
            RST: begin
                state_next = in_abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (in_abort) begin
                    state_next = IDLE;
                end else if (rem == LEN_W'(1)) begin
                    // Chain straight into the next frame when one is accepted now.
                    if (load) state_next = in_reset_first ? RST : SHIFT;
                    else      state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready        = 1'b0;
        out_data        = 1'b0;
        out_state_reset = 1'b0;
        out_bit_valid   = 1'b0;
        out_done        = 1'b0;
        out_busy        = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = !in_abort;
            end
            RST: begin
                out_state_reset = 1'b1;
            end
            SHIFT: begin
                out_data      = shreg[WIDTH-1];
                out_bit_valid = 1'b1;
                out_done      = last_bit;
                in_ready      = last_bit && !in_abort;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_stim_tx.sv
// Directed, table-driven bench for seq_stim_tx (WIDTH=8, LEN_W=5).
module tb_seq_stim_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pattern;
    logic [4:0] in_len;
    logic       in_reset_first;
    logic       in_abort;
    logic       out_data;
    logic       out_state_reset;
    logic       out_bit_valid;
    logic       out_done;
    logic       out_busy;

    seq_stim_tx #(.WIDTH(8), .LEN_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pattern      (in_pattern),
        .in_len          (in_len),
        .in_reset_first  (in_reset_first),
        .in_abort        (in_abort),
        .out_data        (out_data),
        .out_state_reset (out_state_reset),
        .out_bit_valid   (out_bit_valid),
        .out_done        (out_done),
        .out_busy        (out_busy)
    );

    always #5 clk = ~clk;

    // Expected output codes, packed as {in_ready, data, state_reset, bit_valid, done, busy}.
    localparam logic [5:0] IDL = 6'b100000;  // idle, ready
    localparam logic [5:0] IAB = 6'b000000;  // idle with abort held
    localparam logic [5:0] RS  = 6'b001001;  // reset strobe
    localparam logic [5:0] S1  = 6'b010101;  // bit 1, not last
    localparam logic [5:0] S0  = 6'b000101;  // bit 0, not last
    localparam logic [5:0] L1  = 6'b110111;  // last bit 1, done, ready
    localparam logic [5:0] L0  = 6'b100111;  // last bit 0, done, ready

    typedef struct {
        logic       v;
        logic [7:0] pat;
        logic [4:0] len;
        logic       rf;
        logic       ab;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(logic v, logic [7:0] pat, logic [4:0] len,
                                logic rf, logic ab, logic [5:0] exp, string name);
        vec_t t;
        t.v = v; t.pat = pat; t.len = len; t.rf = rf; t.ab = ab; t.exp = exp; t.name = name;
        vecs.push_back(t);
    endfunction

    function automatic logic [5:0] outs();
        return {in_ready, out_data, out_state_reset, out_bit_valid, out_done, out_busy};
    endfunction

    task automatic check(string name, logic [5:0] act, logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy/d/sr/bv/dn/bz=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [7:0] pat, logic [4:0] len, logic rf, logic ab);
        in_valid = v; in_pattern = pat; in_len = len; in_reset_first = rf; in_abort = ab;
    endtask

    initial begin
        logic [5:0] seq_exp [6];

        // Frame B0 len 4: bits 1,0,1,1
        add(1, 8'hB0, 4, 0, 0, IDL, "f1_accept");
        add(0, 8'h00, 0, 0, 0, S1,  "f1_b1");
        add(0, 8'h00, 0, 0, 0, S0,  "f1_b2");
        add(0, 8'h00, 0, 0, 0, S1,  "f1_b3");
        add(0, 8'h00, 0, 0, 0, L1,  "f1_b4_done");
        add(0, 8'h00, 0, 0, 0, IDL, "f1_idle");
        // Frame A5 len 8 with reset strobe: 1,0,1,0,0,1,0,1
        add(1, 8'hA5, 8, 1, 0, IDL, "f2_accept");
        add(0, 8'h00, 0, 0, 0, RS,  "f2_strobe");
        add(0, 8'h00, 0, 0, 0, S1,  "f2_b1");
        add(0, 8'h00, 0, 0, 0, S0,  "f2_b2");
        add(0, 8'h00, 0, 0, 0, S1,  "f2_b3");
        add(0, 8'h00, 0, 0, 0, S0,  "f2_b4");
        add(0, 8'h00, 0, 0, 0, S0,  "f2_b5");
        add(0, 8'h00, 0, 0, 0, S1,  "f2_b6");
        add(0, 8'h00, 0, 0, 0, S0,  "f2_b7");
        add(0, 8'h00, 0, 0, 0, L1,  "f2_b8_done");
        add(0, 8'h00, 0, 0, 0, IDL, "f2_idle");
        // Back-to-back: 90 len 3 (1,0,0) then C0 len 2 held valid (1,1)
        add(1, 8'h90, 3, 0, 0, IDL, "b2b_accept1");
        add(1, 8'hC0, 2, 0, 0, S1,  "b2b_a_b1");
        add(1, 8'hC0, 2, 0, 0, S0,  "b2b_a_b2");
        add(1, 8'hC0, 2, 0, 0, L0,  "b2b_a_b3_accept2");
        add(0, 8'h00, 0, 0, 0, S1,  "b2b_b_b1");
        add(0, 8'h00, 0, 0, 0, L1,  "b2b_b_b2_done");
        add(0, 8'h00, 0, 0, 0, IDL, "b2b_idle");
        // len 0 consumed silently, then len 12 clamps to 8 bits of C3
        add(1, 8'hFF, 0, 1, 0, IDL, "len0_accept");
        add(0, 8'h00, 0, 0, 0, IDL, "len0_quiet");
        add(1, 8'hC3, 12, 0, 0, IDL, "len12_accept");
        add(0, 8'h00, 0, 0, 0, S1,  "len12_b1");
        add(0, 8'h00, 0, 0, 0, S1,  "len12_b2");
        add(0, 8'h00, 0, 0, 0, S0,  "len12_b3");
        add(0, 8'h00, 0, 0, 0, S0,  "len12_b4");
        add(0, 8'h00, 0, 0, 0, S0,  "len12_b5");
        add(0, 8'h00, 0, 0, 0, S0,  "len12_b6");
        add(0, 8'h00, 0, 0, 0, S1,  "len12_b7");
        add(0, 8'h00, 0, 0, 0, L1,  "len12_b8_done");
        add(0, 8'h00, 0, 0, 0, IDL, "len12_idle");
        // Abort on bit 3 of FF len 8 while 81 len 2 is pending
        add(1, 8'hFF, 8, 0, 0, IDL, "ab_accept");
        add(1, 8'h81, 2, 0, 0, S1,  "ab_b1");
        add(1, 8'h81, 2, 0, 0, S1,  "ab_b2");
        add(1, 8'h81, 2, 0, 1, S1,  "ab_b3_abort");
        add(1, 8'h81, 2, 0, 0, IDL, "ab_pending_accept");
        add(0, 8'h00, 0, 0, 0, S1,  "ab_next_b1");
        add(0, 8'h00, 0, 0, 0, L0,  "ab_next_b2_done");
        add(0, 8'h00, 0, 0, 0, IDL, "ab_idle");
        // Abort in IDLE only blocks in_ready
        add(1, 8'hFF, 8, 0, 1, IAB, "ab_idle_block");
        add(0, 8'h00, 0, 0, 0, IDL, "ab_idle_not_taken");

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 0);
        #3;
        check("reset_outputs", {1'b1, outs()[4:0]}, IDL);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_ready", outs(), IDL);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].pat, vecs[i].len, vecs[i].rf, vecs[i].ab);
            #1;
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        drive(1, 8'hAA, 8, 0, 0);
        #1 check("ar_accept", outs(), IDL);
        @(negedge clk);
        drive(0, 8'h00, 0, 0, 0);
        #1 check("ar_b1", outs(), S1);
        @(negedge clk);
        #1 check("ar_b2", outs(), S0);
        #2 rst_n = 1'b0;
        #1 check("ar_immediate", outs(), IDL);
        @(negedge clk);
        #1 check("ar_held", outs(), IDL);
        rst_n = 1'b1;

        // New frame after reset: B0 len 4 with strobe
        seq_exp = '{RS, S1, S0, S1, L1, IDL};
        @(negedge clk);
        drive(1, 8'hB0, 4, 1, 0);
        #1 check("ar_new_accept", outs(), IDL);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(0, 8'h00, 0, 0, 0);
            #1 check($sformatf("ar_new_%0d", k), outs(), seq_exp[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
